hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Owns the HI/LO architectural registers and the iterative MULT/MULTU/DIV/DIVU engine.
//  Supplies execute with forwarded HI/LO from NFWD younger pipeline stages, falling back to the regs.
//  Runs one multi-cycle op at a time with a valid/ready accept, a done pulse and a flush abort.
//  The result travels down the pipeline and is committed back through the write port.
// PARAMETERS
//  WIDTH        32  datapath width; HI/LO width; divider iterations.
//  NFWD         2   forwarding stages; index 0 = youngest, highest priority.
//  MUL_LATENCY  3   cycles from accept to done for MULT/MULTU (>=1).
// PORTS
//  clk          in   1              clock
//  resetn       in   1              asynchronous reset, active-low
//  op_valid     in   1              request present
//  op           in   muldiv_op_t    MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
//  src_a        in   WIDTH          multiplicand / dividend
//  src_b        in   WIDTH          multiplier / divisor
//  op_ready     out  1              engine idle; accept when op_valid&&op_ready
//  flush        in   1              abort in-flight op (exception/branch squash)
//  busy         out  1              op in flight (MUL or DIV state); stall request
//  done         out  1              one-cycle result strobe
//  res_hi       out  WIDTH          product[2W-1:W] / remainder; valid with done
//  res_lo       out  WIDTH          product[W-1:0] / quotient; valid with done
//  fwd          in   hilo_fwd_t[NFWD]  {valid_hi,valid_lo,hi,lo} per stage
//  wr           in   hilo_fwd_t     commit port; valid_hi/valid_lo select regs
//  vhi, vlo     out  WIDTH          forwarded HI/LO read values (combinational)
// BEHAVIOUR
//  Reset: HI=LO=0, state IDLE, done=0, busy=0, op_ready=1, res_hi=res_lo=0.
//  Read mux (per half, independent): lowest i with fwd[i].valid_* wins, else reg.
//   Same-cycle wr is NOT bypassed; vhi/vlo show the new value from the next cycle.
//  Commit: at posedge, wr.valid_hi -> HI<=wr.hi; wr.valid_lo -> LO<=wr.lo; flush does not gate it.
//  FSM IDLE->MUL|DIV on accept; MUL->DONE after MUL_LATENCY-1 more cycles;
//   DIV->FIX after WIDTH iterations -> DONE; DONE->IDLE unconditionally.
//  Latency: accept at edge t; done high in the cycle after edge t+MUL_LATENCY (mul)
//   and after edge t+WIDTH+2 (div).
//  op_ready=(state==IDLE); busy=(state in MUL,DIV,FIX); done=(state==DONE)&&!flush.
//  Operands latch on accept; later src changes are ignored.
//  MULT: signed 2W product; MULTU: unsigned.
//  DIV: restoring radix-2 on |a|,|b|; FIX negates q if sign(a)!=sign(b), r takes sign(a).
//  Divide by zero (both): q = all ones, r = a; no exception.
//  DIV overflow (MIN/-1): q = MIN, r = 0 (natural result of the algorithm, no special case).
//  flush in MUL/DIV/FIX: state->IDLE at the next edge, no done ever issued.
//   A flush in the same cycle as accept also cancels that op.
//  flush in DONE: done is suppressed that cycle; return to IDLE.
//  op_valid while !op_ready is ignored; the requester holds it.
//  res_hi/res_lo hold their last values until the next done.
// STRUCTURE
//  mycpu pkg: muldiv_op_t enum, hilo_fwd_t packed struct, MD_* constants.
//  Sub-module hilo_divider: iterative unsigned core (start, a, b -> q, r, valid).
//  The top level holds the sign pre/post-fix, the mul pipe counter, the FSM, the regs and the fwd mux.
// TESTING
//  1 reset mid-DIV (resetn low at cycle 10) -> immediately op_ready=1, done=0, vhi=vlo=0.
//  2 MULT a=-3 b=5 -> done 3 cycles after accept; res_hi=FFFFFFFF, res_lo=FFFFFFF1.
//  3 DIV a=-7 b=2 -> done 34 cycles after accept; lo=FFFFFFFD, hi=FFFFFFFF; busy high between.
//  4 DIVU a=10 b=0 -> lo=FFFFFFFF, hi=0000000A; DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
//  5 fwd[0].hi=1 valid, fwd[1].hi=2 valid -> vhi=1.
//    Only fwd[1].valid_lo, lo=7 -> vlo=7.
//    None valid after wr HI=9 -> vhi=9 from the next cycle.
//  6 flush at DIV iteration 10 -> no done; op_ready=1 next cycle.
//    MULTU FFFFFFFF*2 accepted -> hi=1, lo=FFFFFFFE.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_unit_pkg
//  Brief    : Shared types for the HI/LO register file and mul/div engine:
//             operation encoding and the HI/LO forward/commit record.
//  Revision : 1.0  initial release
// ============================================================================
package hilo_muldiv_unit_pkg;

   // Architectural HI/LO width; the unit's WIDTH parameter must match it
   // because the forwarding record carries full HI/LO values.
   localparam int c_xlen = 32;

   // Multi-cycle operation selector.
   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } muldiv_op_t;

   // One forwarding stage (or the commit port): per-half valid plus data.
   typedef struct packed {
      logic              valid_hi;
      logic              valid_lo;
      logic [c_xlen-1:0] hi;
      logic [c_xlen-1:0] lo;
   } hilo_fwd_t;

   // Signed operations treat operands as two's complement.
   function automatic logic md_is_signed(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   // Division operations run through the iterative divider.
   function automatic logic md_is_div(input muldiv_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage : hilo_muldiv_unit_pkg
`default_nettype wire

// File: rtl/hilo_divider.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_divider
//  Brief    : Iterative unsigned restoring radix-2 divider. One quotient bit
//             per cycle, WIDTH cycles after start; valid pulses for one cycle
//             with q/r. A zero divisor yields q = all ones, r = a.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             valid
);

   localparam int c_cnt_w = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_dvs;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_busy;
   logic               r_valid;

   // Partial remainder shifted left by one with the next dividend bit; it can
   // need WIDTH+1 bits, so the trial subtraction is one bit wider again to
   // expose the borrow.
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;
   logic             w_borrow;

   // Trial subtraction of the divisor from the shifted partial remainder.
   always_comb begin
      w_shift  = {r_rem, r_quo[WIDTH-1]};
      w_diff   = {1'b0, w_shift} - {2'b00, r_dvs};
      w_borrow = w_diff[WIDTH+1];
   end

   // Iteration state: load on start, one restoring step per cycle while busy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else if (abort) begin
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else if (start) begin
         r_rem   <= '0;
         r_quo   <= a;
         r_dvs   <= b;
         r_cnt   <= c_cnt_w'(WIDTH);
         r_busy  <= 1'b1;
         r_valid <= 1'b0;
      end else if (r_busy) begin
         r_rem   <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
         r_quo   <= {r_quo[WIDTH-2:0], ~w_borrow};
         r_cnt   <= r_cnt - c_cnt_w'(1);
         if (r_cnt == c_cnt_w'(1)) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
         end
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign q     = r_quo;
   assign r     = r_rem;
   assign valid = r_valid;

endmodule : hilo_divider
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_unit
//  Brief    : HI/LO architectural registers with forwarding read mux, plus a
//             single-issue multi-cycle MULT/MULTU/DIV/DIVU engine with
//             valid/ready accept, done strobe and flush abort.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int NFWD        = 2,
   parameter int MUL_LATENCY = 3
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       op_valid,
   input  muldiv_op_t                 op,
   input  logic [WIDTH-1:0]           src_a,
   input  logic [WIDTH-1:0]           src_b,
   output logic                       op_ready,
   input  logic                       flush,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH-1:0]           res_hi,
   output logic [WIDTH-1:0]           res_lo,
   input  hilo_fwd_t [NFWD-1:0]       fwd,
   input  hilo_fwd_t                  wr,
   output logic [WIDTH-1:0]           vhi,
   output logic [WIDTH-1:0]           vlo
);

   localparam int c_mcnt_w = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0]    r_hi;
   logic [WIDTH-1:0]    r_lo;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic                r_signed;
   logic                r_sign_a;
   logic                r_sign_b;
   logic                r_b_zero;
   logic [c_mcnt_w-1:0] r_mul_cnt;
   logic [WIDTH-1:0]    r_pend_hi;
   logic [WIDTH-1:0]    r_pend_lo;
   logic [WIDTH-1:0]    r_res_hi;
   logic [WIDTH-1:0]    r_res_lo;

   logic                w_accept;
   logic                w_op_signed;
   logic                w_op_div;
   logic                w_div_start;
   logic [WIDTH-1:0]    w_abs_a;
   logic [WIDTH-1:0]    w_abs_b;
   logic [WIDTH-1:0]    w_div_q;
   logic [WIDTH-1:0]    w_div_r;
   logic                w_div_valid;
   logic [2*WIDTH-1:0]  w_ext_a;
   logic [2*WIDTH-1:0]  w_ext_b;
   logic [2*WIDTH-1:0]  w_prod;
   logic [WIDTH-1:0]    w_q_fix;
   logic [WIDTH-1:0]    w_r_fix;

   // Request decode and divider operand magnitudes taken straight from the
   // request so the divider can start on the accept edge.
   always_comb begin
      w_accept    = op_valid && (r_state == ST_IDLE);
      w_op_signed = md_is_signed(op);
      w_op_div    = md_is_div(op);
      w_div_start = w_accept && !flush && w_op_div;
      w_abs_a     = (w_op_signed && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
      w_abs_b     = (w_op_signed && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;
   end

   hilo_divider #(
      .WIDTH (WIDTH)
   ) u_divider (
      .clk    (clk),
      .resetn (resetn),
      .start  (w_div_start),
      .abort  (flush),
      .a      (w_abs_a),
      .b      (w_abs_b),
      .q      (w_div_q),
      .r      (w_div_r),
      .valid  (w_div_valid)
   );

   // Full-width product of the latched operands; sign extension to 2*WIDTH
   // makes the low 2*WIDTH bits of the product correct for both signednesses.
   always_comb begin
      w_ext_a = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
      w_ext_b = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
      w_prod  = w_ext_a * w_ext_b;
   end

   // Sign post-fix: quotient negated on differing signs (never for a zero
   // divisor, which must stay all ones), remainder follows the dividend.
   always_comb begin
      w_q_fix = (r_signed && (r_sign_a ^ r_sign_b) && !r_b_zero) ? (~w_div_q + 1'b1) : w_div_q;
      w_r_fix = (r_signed && r_sign_a) ? (~w_div_r + 1'b1) : w_div_r;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and handshake outputs; flush aborts any in-flight op.
   always_comb begin
      w_state_nxt = r_state;
      op_ready    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            op_ready = 1'b1;
            if (w_accept && !flush) begin
               w_state_nxt = w_op_div ? ST_DIV : ST_MUL;
            end
         end
         ST_MUL: begin
            busy = 1'b1;
            if (flush) begin
               w_state_nxt = ST_IDLE;
            end else if (r_mul_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DIV: begin
            busy = 1'b1;
            if (flush) begin
               w_state_nxt = ST_IDLE;
            end else if (w_div_valid) begin
               w_state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            busy        = 1'b1;
            w_state_nxt = flush ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            done        = !flush;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Operand/sign capture on accept and the multiplier latency countdown.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_a       <= '0;
         r_b       <= '0;
         r_signed  <= 1'b0;
         r_sign_a  <= 1'b0;
         r_sign_b  <= 1'b0;
         r_b_zero  <= 1'b0;
         r_mul_cnt <= '0;
      end else if (w_accept) begin
         r_a       <= src_a;
         r_b       <= src_b;
         r_signed  <= w_op_signed;
         r_sign_a  <= src_a[WIDTH-1];
         r_sign_b  <= src_b[WIDTH-1];
         r_b_zero  <= (src_b == '0);
         r_mul_cnt <= c_mcnt_w'(MUL_LATENCY - 1);
      end else if ((r_state == ST_MUL) && (r_mul_cnt != '0)) begin
         r_mul_cnt <= r_mul_cnt - c_mcnt_w'(1);
      end
   end

   // Pending result captured on the way into DONE; it becomes the held
   // result only when done actually fires, so a flushed DONE leaves the
   // previous result visible.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_res_hi  <= '0;
         r_res_lo  <= '0;
      end else begin
         if ((r_state == ST_MUL) && (r_mul_cnt == '0)) begin
            r_pend_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_pend_lo <= w_prod[WIDTH-1:0];
         end else if (r_state == ST_FIX) begin
            r_pend_hi <= w_r_fix;
            r_pend_lo <= w_q_fix;
         end
         if (done) begin
            r_res_hi <= r_pend_hi;
            r_res_lo <= r_pend_lo;
         end
      end
   end

   assign res_hi = done ? r_pend_hi : r_res_hi;
   assign res_lo = done ? r_pend_lo : r_res_lo;

   // HI/LO commit from the write-back port, independent of flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (wr.valid_hi) begin
            r_hi <= wr.hi;
         end
         if (wr.valid_lo) begin
            r_lo <= wr.lo;
         end
      end
   end

   // Forwarding read mux: scan oldest to youngest so the lowest index wins.
   always_comb begin
      vhi = r_hi;
      vlo = r_lo;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (fwd[i].valid_hi) begin
            vhi = fwd[i].hi;
         end
         if (fwd[i].valid_lo) begin
            vlo = fwd[i].lo;
         end
      end
   end

endmodule : hilo_muldiv_unit
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_muldiv_unit
//  Brief    : Directed self-checking bench for hilo_muldiv_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_unit;
   import hilo_muldiv_unit_pkg::*;

   logic                clk;
   logic                resetn;
   logic                op_valid;
   muldiv_op_t          op;
   logic [31:0]         src_a;
   logic [31:0]         src_b;
   logic                op_ready;
   logic                flush;
   logic                busy;
   logic                done;
   logic [31:0]         res_hi;
   logic [31:0]         res_lo;
   hilo_fwd_t [1:0]     fwd;
   hilo_fwd_t           wr;
   logic [31:0]         vhi;
   logic [31:0]         vlo;

   int n_checks;
   int n_errors;
   int lat;
   int seen_done;
   logic all_busy;

   hilo_muldiv_unit #(
      .WIDTH       (32),
      .NFWD        (2),
      .MUL_LATENCY (3)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .op_valid (op_valid),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .op_ready (op_ready),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .res_hi   (res_hi),
      .res_lo   (res_lo),
      .fwd      (fwd),
      .wr       (wr),
      .vhi      (vhi),
      .vlo      (vlo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one op for a single accept edge, then scramble the operands.
   task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1;
      op       = o;
      src_a    = a;
      src_b    = b;
      step();
      op_valid = 1'b0;
      src_a    = 32'hDEAD_BEEF;
      src_b    = 32'h1234_5678;
   endtask

   // Count edges after the accept edge until done; also track busy.
   task automatic wait_done();
      lat      = 0;
      all_busy = 1'b1;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) all_busy = 1'b0;
         step();
         lat++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      resetn   = 1'b0;
      op_valid = 1'b0;
      op       = MD_MULT;
      src_a    = '0;
      src_b    = '0;
      flush    = 1'b0;
      fwd      = '0;
      wr       = '0;
      step();
      step();
      resetn = 1'b1;
      step();

      // Reset state
      chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_done",     {31'd0, done},     32'd0);
      chk("rst_res_hi",   res_hi,            32'd0);
      chk("rst_res_lo",   res_lo,            32'd0);
      chk("rst_vhi",      vhi,               32'd0);

      // 1: commit HI/LO, start a DIVU, then async reset mid-divide
      wr = {1'b1, 1'b1, 32'h0000_0011, 32'h0000_0022};
      step();
      wr = '0;
      chk("wr_vlo", vlo, 32'h0000_0022);
      issue(MD_DIVU, 32'd100, 32'd7);
      for (int i = 0; i < 9; i++) step();
      chk("div_busy_mid", {31'd0, busy}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("arst_op_ready", {31'd0, op_ready}, 32'd1);
      chk("arst_done",     {31'd0, done},     32'd0);
      chk("arst_vhi",      vhi,               32'd0);
      chk("arst_vlo",      vlo,               32'd0);
      step();
      resetn = 1'b1;
      step();

      // 2: MULT -3 * 5
      issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
      wait_done();
      chk("mult_latency", lat, 32'd3);
      chk("mult_hi", res_hi, 32'hFFFF_FFFF);
      chk("mult_lo", res_lo, 32'hFFFF_FFF1);
      step();
      chk("mult_done_pulse", {31'd0, done}, 32'd0);
      chk("mult_hold_lo", res_lo, 32'hFFFF_FFF1);

      // 3: DIV -7 / 2
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done();
      chk("div_latency", lat, 32'd34);
      chk("div_busy_between", {31'd0, all_busy}, 32'd1);
      chk("div_lo", res_lo, 32'hFFFF_FFFD);
      chk("div_hi", res_hi, 32'hFFFF_FFFF);
      step();

      // 4: divide by zero and signed overflow
      issue(MD_DIVU, 32'd10, 32'd0);
      wait_done();
      chk("divu0_lo", res_lo, 32'hFFFF_FFFF);
      chk("divu0_hi", res_hi, 32'h0000_000A);
      step();
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd0);
      wait_done();
      chk("div0_lo", res_lo, 32'hFFFF_FFFF);
      chk("div0_hi", res_hi, 32'hFFFF_FFF9);
      step();
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done();
      chk("divovf_lo", res_lo, 32'h8000_0000);
      chk("divovf_hi", res_hi, 32'h0000_0000);
      step();

      // 5: forwarding priority and commit timing
      fwd[0] = {1'b1, 1'b0, 32'd1, 32'd0};
      fwd[1] = {1'b1, 1'b0, 32'd2, 32'd0};
      #1;
      chk("fwd_prio_vhi", vhi, 32'd1);
      fwd[0] = '0;
      fwd[1] = {1'b0, 1'b1, 32'd5, 32'd7};
      #1;
      chk("fwd1_vlo", vlo, 32'd7);
      chk("fwd1_vhi_reg", vhi, 32'd0);
      fwd = '0;
      wr  = {1'b1, 1'b0, 32'd9, 32'd0};
      #1;
      chk("wr_no_bypass", vhi, 32'd0);
      step();
      wr = '0;
      chk("wr_next_cycle", vhi, 32'd9);

      // 6: flush mid-divide, flush at accept, flush in DONE, then MULTU
      issue(MD_DIV, 32'd1000, 32'd3);
      for (int i = 0; i < 10; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_op_ready", {31'd0, op_ready}, 32'd1);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) seen_done++;
         step();
      end
      chk("flush_no_done", seen_done, 32'd0);

      op_valid = 1'b1;
      op       = MD_MULT;
      src_a    = 32'd4;
      src_b    = 32'd4;
      flush    = 1'b1;
      step();
      op_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_at_accept", {31'd0, op_ready}, 32'd1);

      issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      wait_done();
      chk("multu_latency", lat, 32'd3);
      chk("multu_hi", res_hi, 32'h0000_0001);
      chk("multu_lo", res_lo, 32'hFFFF_FFFE);
      step();

      issue(MD_MULT, 32'd6, 32'd7);
      step();
      step();
      step();
      flush = 1'b1;
      #1;
      chk("flush_done_suppr", {31'd0, done}, 32'd0);
      chk("flush_done_hold", res_lo, 32'hFFFF_FFFE);
      step();
      flush = 1'b0;
      chk("flush_done_idle", {31'd0, op_ready}, 32'd1);
      chk("flush_done_nodone", {31'd0, done}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_hilo_muldiv_unit
`default_nettype wire
